// File: rtl/sub_bytes_engine_if.sv
// Start/done handshake and state buses between the round controller and the SubBytes engine.
// Latency: none, wires only.
// Backpressure: none. start is honoured only when the engine is idle or finishing, and done pulses for one cycle.
interface sub_bytes_engine_if #(
    parameter int NB = 16
);
    logic            start;
    logic            inverse;
    logic [8*NB-1:0] state_in;
    logic            busy;
    logic            done;
    logic [8*NB-1:0] state_out;

    modport master (
        output start, inverse, state_in,
        input  busy, done, state_out
    );

    modport slave (
        input  start, inverse, state_in,
        output busy, done, state_out
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes/InvSubBytes over an NB-byte AES state, LANES S-box lookups per cycle.
// Latency: done is high in the cycle after edge T+NB/LANES+REG_LOOKUP, where T is the start sample edge (4 with defaults).
// Backpressure: start is ignored while busy and there is no queuing; done is a one-cycle pulse with state_out held until the next done.
module sub_bytes_engine #(
    parameter int NB         = 16,
    parameter int LANES      = 4,
    parameter int REG_LOOKUP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    sub_bytes_engine_if.slave     bus
);
    localparam int BEATS = NB / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    // The state has to split into whole beats of LANES bytes.
    if ((LANES < 1) || (NB % LANES != 0)) begin : g_bad_lanes
        $error("sub_bytes_engine: NB must be a non-zero multiple of LANES");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q;
    logic [BW-1:0]      beat_q;
    logic [BW-1:0]      pipe_beat_q;
    logic               mode_q;
    logic [8*NB-1:0]    work_q;
    logic [8*NB-1:0]    result_q;
    logic [8*NB-1:0]    result_d;
    logic [8*LANES-1:0] pipe_q;
    logic [8*LANES-1:0] lookup_d;
    logic               busy_q;
    logic               done_q;
    logic [8*NB-1:0]    state_out_q;

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        case (x)
            8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
            8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
            8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
            8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
            8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
            8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
            8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
            8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
            8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
            8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
            8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
            8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
            8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
            8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
            8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
            8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
            8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
            8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
            8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
            8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
            8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
            8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
            8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
            8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
            8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
            8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
            8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
            8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
            8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
            8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
            8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
            8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        case (x)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
        endcase
        return r;
    endfunction

    // Each lane owns a forward and an inverse ROM; the mode latched at start picks one.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [7:0] lane_in;
        assign lane_in = work_q[8*(int'(beat_q)*LANES + j) +: 8];
        assign lookup_d[8*j +: 8] = mode_q ? sbox_inv(lane_in) : sbox_fwd(lane_in);
    end

    // Result path: merge this cycle's substituted bytes (direct or from the pipe stage) into the result.
    always_comb begin
        result_d = result_q;
        if (REG_LOOKUP == 0) begin
            if (state_q == S_RUN) begin
                for (int j = 0; j < LANES; j++) begin
                    result_d[8*(int'(beat_q)*LANES + j) +: 8] = lookup_d[8*j +: 8];
                end
            end
        end else begin
            // At beat 0 the pipe still holds the previous operation's last beat, so skip it.
            if ((state_q == S_RUN && beat_q != '0) || state_q == S_DRAIN) begin
                for (int j = 0; j < LANES; j++) begin
                    result_d[8*(int'(pipe_beat_q)*LANES + j) +: 8] = pipe_q[8*j +: 8];
                end
            end
        end
    end

    // Control FSM with registered busy/done/state_out; DONE can relaunch directly into RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            pipe_beat_q <= '0;
            mode_q      <= 1'b0;
            work_q      <= '0;
            result_q    <= '0;
            pipe_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            state_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        work_q  <= bus.state_in;
                        mode_q  <= bus.inverse;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    if (REG_LOOKUP != 0) begin
                        pipe_q      <= lookup_d;
                        pipe_beat_q <= beat_q;
                    end
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        if (REG_LOOKUP != 0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_out_q <= result_d;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_DRAIN: begin
                    result_q    <= result_d;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_out_q <= result_d;
                    state_q     <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_out = state_out_q;
endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
Multi-lane, iterative SubBytes / InvSubBytes engine for the AES datapath.
- Accepts an NB-byte state and substitutes LANES bytes per clock through LANES replicated S-box lookups.
- Lookups are forward (FIPS-197 S-box) or inverse (FIPS-197 inverse S-box), selected per operation.
- Sits between AddRoundKey and ShiftRows in the round controller; start/done handshake.
- Lets the team trade area (lane count) against latency.

Parameters:
- NB, 16, state width in bytes.
- LANES, 4, S-box lookups per cycle; NB % LANES must be 0, otherwise elaboration error.
- REG_LOOKUP, 0, 1 = insert a register stage after the lookups (one extra cycle latency, shorter critical path).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin operation; sampled only in IDLE or DONE
- inverse  in  1  0 = SubBytes, 1 = InvSubBytes; sampled with start
- state_in  in  8*NB  input state; byte i = state_in[8i+7:8i]; sampled with start
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse, result valid
- state_out  out  8*NB  substituted state; byte i at [8i+7:8i]

Behaviour:
- Reset: asynchronous, active-high, takes effect immediately regardless of clk. FSM=IDLE, beat=0, busy=0, done=0, state_out=0, internal work/result regs=0, mode reg=0.
- BEATS = NB/LANES. Beat counter width is clog2(BEATS), minimum 1.
- States:
  - IDLE: if start, latch state_in into work reg and inverse into mode reg; beat=0; go to RUN.
  - RUN: lanes j=0..LANES-1 substitute work byte beat*LANES+j using the mode selected at start.
    - REG_LOOKUP=0: the result is written to the same byte position of the result reg on this edge.
    - REG_LOOKUP=1: the lookup output and its byte index are captured in a pipe reg, and the previous beat's pipe reg is written to the result reg.
    - beat increments each cycle. At beat==BEATS-1, go to DRAIN if REG_LOOKUP=1, else to DONE.
  - DRAIN (REG_LOOKUP=1 only): commit the final pipe reg to the result reg; go to DONE.
  - DONE: done=1 for exactly this cycle, and state_out shows the full substituted state this cycle.
    - If start is high, latch a new operation and go to RUN (back-to-back, no idle bubble); else go to IDLE.
- state_out update: loaded from the result path on the edge entering DONE; holds until the next DONE.
- Latency: start sampled at edge T gives done high in the cycle after edge T+BEATS+REG_LOOKUP.
  - Defaults: 4 cycles.
  - LANES=NB, REG_LOOKUP=0: 1 cycle.
- start in RUN/DRAIN is ignored; no queuing. Changes to inverse/state_in after the start sample have no effect.
- Reset asserted mid-operation aborts immediately: no done pulse, state_out=0.
- Lookup tables are combinational case ROMs, one forward and one inverse per lane, muxed by the mode reg. All 256 entries of both tables are required.

Test Plan:
- Defaults, forward: state_in bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, start one cycle -> done 4 cycles later, busy high for 4 cycles, state_out bytes = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- Inverse round-trip: feed that output with inverse=1 -> state_out equals the original input. Single bytes: 0x63->0x00, 0xED->0x53, 0x16->0xFF.
- Exhaustive tables, LANES=16, REG_LOOKUP=1: sweep each of 256 values in all lanes, both modes -> matches the FIPS-197 tables; done 2 cycles after start. Also check LANES=1, REG_LOOKUP=0 -> done after 16 cycles.
- Back-to-back: start held high continuously across DONE -> done pulses every 5th cycle (defaults), no gap, each result correct. start pulsed during RUN -> ignored, exactly one done.
- Mode/data isolation: toggle inverse and state_in every cycle after the start sample -> result depends only on values at the start sample.
- Reset mid-operation: assert rst at beat 2 -> busy, done, state_out immediately 0 and FSM IDLE. Deassert, then start with all-zero state -> state_out all 0x63.
